// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry and mret return sequencer.
// Picks one event at commit (exception > interrupt > mret), drains the
// pipeline, writes the trap CSRs for one cycle, then redirects fetch.
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter bit VEC_EN       = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        commit_exc,
  input  logic [5:0]  commit_cause,
  input  logic [63:0] commit_tval,
  input  logic        commit_mret,
  output logic        commit_ready,
  input  logic [63:0] mstatus_csr_out,
  input  logic [63:0] mip_csr_out,
  input  logic [63:0] mie_csr_out,
  input  logic [63:0] mtvec_csr_out,
  input  logic [63:0] mepc_csr_out,
  output logic        flush,
  input  logic        flush_ack,
  output logic [3:0]  csr_wen,
  output logic [63:0] mepc_except_in,
  output logic [63:0] mcause_except_in,
  output logic [63:0] mtval_except_in,
  output logic [63:0] mstatus_except_in,
  output logic        pc_redirect_valid,
  output logic [63:0] pc_redirect,
  output logic        trap_busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, WRCSR, REDIR} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  kind_t       kind, evt_kind;
  logic [3:0]  cnt;
  logic [63:0] cap_pc, cap_tval, target, target_nxt;
  logic [5:0]  cap_cause, evt_cause;
  logic [63:0] evt_tval;
  logic        take_evt;

  logic        irq_ext, irq_sw, irq_tm, irq_any;
  logic [5:0]  irq_cause;
  logic [63:0] vec_base;
  logic        unused_bits;

  assign irq_ext   = mstatus_csr_out[3] & mip_csr_out[11] & mie_csr_out[11];
  assign irq_sw    = mstatus_csr_out[3] & mip_csr_out[3]  & mie_csr_out[3];
  assign irq_tm    = mstatus_csr_out[3] & mip_csr_out[7]  & mie_csr_out[7];
  assign irq_any   = irq_ext | irq_sw | irq_tm;
  assign irq_cause = irq_ext ? 6'd11 : (irq_sw ? 6'd3 : 6'd7);
  assign vec_base  = {mtvec_csr_out[63:2], 2'b00};

  assign unused_bits = &{1'b0, mip_csr_out[63:12], mip_csr_out[10:8], mip_csr_out[6:4],
                         mip_csr_out[2:0], mie_csr_out[63:12], mie_csr_out[10:8],
                         mie_csr_out[6:4], mie_csr_out[2:0]};

  // Next-state, event capture selection and all strobed outputs
  always_comb begin
    state_nxt         = state;
    target_nxt        = target;
    take_evt          = 1'b0;
    evt_kind          = KIND_EXC;
    evt_cause         = 6'd0;
    evt_tval          = 64'd0;
    commit_ready      = 1'b0;
    flush             = 1'b0;
    csr_wen           = 4'b0000;
    mepc_except_in    = 64'd0;
    mcause_except_in  = 64'd0;
    mtval_except_in   = 64'd0;
    mstatus_except_in = 64'd0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = 64'd0;
    trap_busy         = (state != IDLE);
    case (state)
      IDLE: begin
        commit_ready = 1'b1;
        if (commit_valid) begin
          if (commit_exc) begin
            take_evt  = 1'b1;
            evt_kind  = KIND_EXC;
            evt_cause = commit_cause;
            evt_tval  = commit_tval;
          end else if (irq_any) begin
            take_evt     = 1'b1;
            commit_ready = 1'b0;
            evt_kind     = KIND_IRQ;
            evt_cause    = irq_cause;
          end else if (commit_mret) begin
            take_evt = 1'b1;
            evt_kind = KIND_MRET;
          end
        end
        if (take_evt) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if ((cnt >= FLUSH_LAST) && flush_ack) state_nxt = WRCSR;
      end
      WRCSR: begin
        state_nxt = REDIR;
        if (kind == KIND_MRET) begin
          csr_wen               = 4'b1000;
          mstatus_except_in     = mstatus_csr_out;
          mstatus_except_in[3]  = mstatus_csr_out[7];
          mstatus_except_in[7]  = 1'b1;
          mstatus_except_in[12:11] = 2'b11;
          target_nxt            = mepc_csr_out;
        end else begin
          csr_wen               = 4'b1111;
          mepc_except_in        = {cap_pc[63:2], 2'b00};
          mcause_except_in      = {(kind == KIND_IRQ), 57'd0, cap_cause};
          mtval_except_in       = cap_tval;
          mstatus_except_in     = mstatus_csr_out;
          mstatus_except_in[7]  = mstatus_csr_out[3];
          mstatus_except_in[3]  = 1'b0;
          mstatus_except_in[12:11] = 2'b11;
          if (VEC_EN && (kind == KIND_IRQ) && (mtvec_csr_out[1:0] == 2'b01))
            target_nxt = vec_base + {56'd0, cap_cause, 2'b00};
          else
            target_nxt = vec_base;
        end
      end
      REDIR: begin
        pc_redirect_valid = 1'b1;
        pc_redirect       = target;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, drain counter, captured event and latched redirect target
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      kind      <= KIND_EXC;
      cnt       <= 4'd0;
      cap_pc    <= 64'd0;
      cap_cause <= 6'd0;
      cap_tval  <= 64'd0;
      target    <= 64'd0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      if (take_evt) begin
        kind      <= evt_kind;
        cap_pc    <= commit_pc;
        cap_cause <= evt_cause;
        cap_tval  <= evt_tval;
      end
      if (state != FLUSH)
        cnt <= 4'd0;
      else if (cnt != 4'hF)
        cnt <= cnt + 4'd1;
    end
  end

endmodule
